// File: rtl/timer_host_ctl.sv
// timer_host_ctl
//   Avalon-MM master that drives a 16-bit-data interval-timer slave with a
//   3-bit word address. It programs the period and control registers, starts
//   and stops the timer, and services timeouts by interrupt or by status
//   polling. Each timeout is cleared on the slave and counted. On request it
//   reads a 32-bit counter snapshot from the slave.
//
//   Slave register map (word addresses):
//     0 status   : write clears TO; read bit0 = TO, bit1 = RUN
//     1 control  : b0 ITO, b1 CONT, b2 START, b3 STOP
//     2/3 period : low / high 16 bits
//     4/5 snap   : low / high 16 bits; a write to either latches the counter
//
// Ports
//   clk, reset     system clock, synchronous active-high reset
//   cmd_start      pulse: program and start the timer (taken in IDLE only)
//   cmd_stop       pulse: stop the timer (latched while busy)
//   cfg_period     period load value, sampled with an accepted cmd_start
//   cfg_cont       continuous mode, sampled with an accepted cmd_start
//   cfg_irq_en     1 = service on timer_irq, 0 = poll the status register
//   snap_req       pulse: capture a counter snapshot (latched, done from RUN)
//   av_*           Avalon-MM master towards the timer slave
//   timer_irq      timer interrupt request (level)
//   busy           high whenever the controller is not in IDLE
//   tick           one-cycle pulse per serviced timeout
//   tick_count     serviced timeouts since the last cmd_start, wraps
//   snap_value     last captured snapshot {hi, lo}
//   snap_valid     one-cycle pulse while a new snapshot is presented
module timer_host_ctl #(
    parameter int POLL_GAP = 2,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    input  logic [31:0]      cfg_period,
    input  logic             cfg_cont,
    input  logic             cfg_irq_en,
    input  logic             snap_req,
    output logic [2:0]       av_address,
    output logic             av_chipselect,
    output logic             av_write_n,
    output logic [15:0]      av_writedata,
    input  logic [15:0]      av_readdata,
    input  logic             timer_irq,
    output logic             busy,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count,
    output logic [31:0]      snap_value,
    output logic             snap_valid
);

    localparam int GAP_W = $clog2(POLL_GAP + 1);

    localparam logic [2:0]  A_STATUS  = 3'd0;
    localparam logic [2:0]  A_CTRL    = 3'd1;
    localparam logic [2:0]  A_PER_LO  = 3'd2;
    localparam logic [2:0]  A_PER_HI  = 3'd3;
    localparam logic [2:0]  A_SNAP_LO = 3'd4;
    localparam logic [2:0]  A_SNAP_HI = 3'd5;
    localparam logic [15:0] CTL_STOP  = 16'h0008;

    typedef enum logic [3:0] {
        IDLE, W_STOP, W_PL, W_PH, W_CLR, W_CTL,
        RUN, SVC, HALT, S_W, S_RL, S_RH, S_CAP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [31:0]      period;
    logic             cont;
    logic             irq_en;
    logic             stop_pend;
    logic             snap_pend;
    logic [15:0]      snap_lo;
    logic [31:0]      snap_hold;
    logic [GAP_W-1:0] ignore_cnt;
    logic             service;

    // A timeout is pending either on the irq line or, in poll mode, when the
    // status read issued in the previous RUN cycle came back with TO set and
    // the read is not inside the post-clear ignore window.
    assign service = irq_en ? timer_irq : (av_readdata[0] && (ignore_cnt == '0));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and bus outputs; every state issues at most one bus cycle.
    always_comb begin
        state_next    = state;
        av_chipselect = 1'b0;
        av_write_n    = 1'b1;
        av_address    = A_STATUS;
        av_writedata  = 16'h0000;
        case (state)
            IDLE: begin
                if (cmd_start) state_next = W_STOP;
            end
            W_STOP: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = A_CTRL;
                av_writedata  = CTL_STOP;
                state_next    = W_PL;
            end
            W_PL: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = A_PER_LO;
                av_writedata  = period[15:0];
                state_next    = W_PH;
            end
            W_PH: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = A_PER_HI;
                av_writedata  = period[31:16];
                state_next    = W_CLR;
            end
            W_CLR: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = A_STATUS;
                state_next    = W_CTL;
            end
            W_CTL: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = A_CTRL;
                av_writedata  = {12'h000, 1'b0, 1'b1, cont, irq_en};
                state_next    = RUN;
            end
            RUN: begin
                // Poll mode keeps a status read in flight every RUN cycle.
                if (!irq_en) av_chipselect = 1'b1;
                if (service)        state_next = SVC;
                else if (stop_pend) state_next = HALT;
                else if (snap_pend) state_next = S_W;
            end
            SVC: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = A_STATUS;
                state_next    = RUN;
            end
            HALT: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = A_CTRL;
                av_writedata  = CTL_STOP;
                state_next    = IDLE;
            end
            S_W: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = A_SNAP_LO;
                state_next    = S_RL;
            end
            S_RL: begin
                av_chipselect = 1'b1;
                av_address    = A_SNAP_LO;
                state_next    = S_RH;
            end
            S_RH: begin
                av_chipselect = 1'b1;
                av_address    = A_SNAP_HI;
                state_next    = S_CAP;
            end
            S_CAP: begin
                state_next = RUN;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Configuration capture, tick counter, command latches, poll ignore
    // window and snapshot capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            period     <= 32'h0;
            cont       <= 1'b0;
            irq_en     <= 1'b0;
            tick_count <= '0;
            stop_pend  <= 1'b0;
            snap_pend  <= 1'b0;
            ignore_cnt <= '0;
            snap_lo    <= 16'h0;
            snap_hold  <= 32'h0;
        end else begin
            if (state == IDLE && cmd_start) begin
                period     <= cfg_period;
                cont       <= cfg_cont;
                irq_en     <= cfg_irq_en;
                tick_count <= '0;
            end else if (state == SVC) begin
                tick_count <= tick_count + CNT_W'(1);
            end

            if (state == HALT) begin
                stop_pend <= 1'b0;
            end else if (cmd_stop && state != IDLE) begin
                stop_pend <= 1'b1;
            end

            // A snapshot still pending when the timer is halted is dropped.
            if (state == HALT || state == S_W) begin
                snap_pend <= 1'b0;
            end else if (snap_req && state != IDLE) begin
                snap_pend <= 1'b1;
            end

            // After a clear, readdata may still carry the old TO bit, so it is
            // ignored for POLL_GAP cycles. On any other entry into RUN the
            // first readdata does not belong to a status read, so skip one.
            if (state == SVC) begin
                ignore_cnt <= GAP_W'(POLL_GAP);
            end else if (state != RUN && state_next == RUN) begin
                ignore_cnt <= GAP_W'(1);
            end else if (ignore_cnt != '0) begin
                ignore_cnt <= ignore_cnt - GAP_W'(1);
            end

            if (state == S_RH) snap_lo <= av_readdata;
            if (state == S_CAP) snap_hold <= {av_readdata, snap_lo};
        end
    end

    // During S_CAP the high half is still on readdata, so present it directly
    // so that snap_value is already the new snapshot while snap_valid is high.
    assign snap_value = (state == S_CAP) ? {av_readdata, snap_lo} : snap_hold;
    assign snap_valid = (state == S_CAP);
    assign tick       = (state == SVC);
    assign busy       = (state != IDLE);

endmodule
